gray_seq_ctrl: RTL

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//
// Sequencer that counts a binary value from 0 up to a latched terminal count
// and presents it as registered Gray code. Each count value is held for DIV
// clock cycles. The sequence can be paused, aborted or reset at any time.
// Completion is signalled by a single-cycle done pulse.
//
// Parameters
//   WIDTH     count and Gray output width in bits (>= 2)
//   DIV       clock cycles per count step (>= 1)
//
// Ports
//   clk       clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   start     start request, honoured only in IDLE
//   pause     level, freezes the sequence while high in RUN/HOLD
//   abort     level, forces return to IDLE from any state
//   limit     binary terminal count, latched when a start is accepted
//   gray_out  registered Gray code of the internal binary count
//   busy      high in RUN and HOLD
//   done      one-cycle pulse when the sequence completes

module gray_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic             done
);

    // Prescaler needs at least one bit even when DIV == 1.
    localparam int unsigned      PSC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [PSC_W-1:0] psc_q, psc_d;

    logic accept;
    logic step;
    logic at_limit;

    assign accept   = (state_q == StIdle) && start && !abort;
    assign step     = (state_q == StRun) && (psc_q == PSC_LAST);
    assign at_limit = (cnt_q == lim_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // abort wins over everything; a terminal step wins over pause, and a
    // pause seen in a non-terminal step cycle lands in HOLD after the step.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (step && at_limit) begin
                        state_d = StDone;
                    end else if (pause) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (!pause) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StRun:   busy = 1'b1;
            StHold:  busy = 1'b1;
            StDone:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: count, prescaler, latched limit
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        psc_d = psc_q;
        lim_d = lim_q;
        if (abort) begin
            cnt_d = '0;
            psc_d = '0;
        end else if (accept) begin
            cnt_d = '0;
            psc_d = '0;
            lim_d = limit;
        end else if (state_q == StRun) begin
            if (step) begin
                psc_d = '0;
                // At the terminal count the value is held into DONE/IDLE.
                if (!at_limit) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (!pause) begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    // Gray encoding of the current count; registered, so it trails cnt by
    // one cycle.
    always_comb begin
        gray_d = cnt_q ^ (cnt_q >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            psc_q  <= '0;
            lim_q  <= '0;
            gray_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            psc_q  <= psc_d;
            lim_q  <= lim_d;
            gray_q <= gray_d;
        end
    end

    assign gray_out = gray_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    a_busy_done_excl : assert property (
        @(posedge clk) disable iff (!rst_n) !(busy && done)
    );

    a_psc_range : assert property (
        @(posedge clk) disable iff (!rst_n) (psc_q <= PSC_LAST)
    );

    a_cnt_bounded : assert property (
        @(posedge clk) disable iff (!rst_n) (!busy || (cnt_q <= lim_q))
    );
`endif

endmodule
